// File: rtl/reg_file_2r1w_if.sv
// Register-file access bundle: write port, two operand read ports, one debug
// read port and the last-write trace outputs.
//   master: drives reg_write/wr_addr/wr_data/rd_addr1/rd_addr2/dbg_addr,
//           receives rd_data1/rd_data2/dbg_data/last_wr_*
//   slave : the register file side
interface reg_file_2r1w_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              reg_write;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic [DATA_W-1:0] dbg_data;
    logic              last_wr_vld;
    logic [ADDR_W-1:0] last_wr_addr;
    logic [DATA_W-1:0] last_wr_data;

    modport master (
        output reg_write, wr_addr, wr_data, rd_addr1, rd_addr2, dbg_addr,
        input  rd_data1, rd_data2, dbg_data, last_wr_vld, last_wr_addr, last_wr_data
    );

    modport slave (
        input  reg_write, wr_addr, wr_data, rd_addr1, rd_addr2, dbg_addr,
        output rd_data1, rd_data2, dbg_data, last_wr_vld, last_wr_addr, last_wr_data
    );
endinterface

// File: rtl/reg_file_2r1w.sv
// Register file for the MIPS single-cycle datapath: 2**ADDR_W x DATA_W storage,
// one write port, two combinational operand read ports (optional write-through
// bypass), one never-bypassed debug read port and a last-write trace register.
// Register 0 reads as zero and ignores writes.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears storage and trace
//   rf    : reg_file_2r1w_if slave (write, read, debug, trace signals)
module reg_file_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    reg_file_2r1w_if.slave rf
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
    logic                         last_wr_vld_q, last_wr_vld_d;
    logic [ADDR_W-1:0]            last_wr_addr_q, last_wr_addr_d;
    logic [DATA_W-1:0]            last_wr_data_q, last_wr_data_d;

    // Writes to index 0 are dropped entirely, including from the trace.
    logic wr_commit;
    assign wr_commit = rf.reg_write && (rf.wr_addr != '0);

    always_comb begin
        regs_d         = regs_q;
        last_wr_vld_d  = last_wr_vld_q;
        last_wr_addr_d = last_wr_addr_q;
        last_wr_data_d = last_wr_data_q;
        if (wr_commit) begin
            regs_d[rf.wr_addr] = rf.wr_data;
            last_wr_vld_d      = 1'b1;
            last_wr_addr_d     = rf.wr_addr;
            last_wr_data_d     = rf.wr_data;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q         <= '0;
            last_wr_vld_q  <= 1'b0;
            last_wr_addr_q <= '0;
            last_wr_data_q <= '0;
        end else begin
            regs_q         <= regs_d;
            last_wr_vld_q  <= last_wr_vld_d;
            last_wr_addr_q <= last_wr_addr_d;
            last_wr_data_q <= last_wr_data_d;
        end
    end

    // Read ports. Index 0 never matches a committed write, so reads of $0
    // always come from regs_q[0], which is held at zero.
    always_comb begin
        rf.rd_data1 = regs_q[rf.rd_addr1];
        if (BYPASS && wr_commit && (rf.rd_addr1 == rf.wr_addr))
            rf.rd_data1 = rf.wr_data;
    end

    always_comb begin
        rf.rd_data2 = regs_q[rf.rd_addr2];
        if (BYPASS && wr_commit && (rf.rd_addr2 == rf.wr_addr))
            rf.rd_data2 = rf.wr_data;
    end

    assign rf.dbg_data     = regs_q[rf.dbg_addr];
    assign rf.last_wr_vld  = last_wr_vld_q;
    assign rf.last_wr_addr = last_wr_addr_q;
    assign rf.last_wr_data = last_wr_data_q;
endmodule
